// File: rtl/bridge_pkg.sv
// Shared types and helpers for the multi-slave AHB-Lite to APB bridge.
package bridge_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WWAIT,
      ST_SETUP,
      ST_ACCESS,
      ST_ERR1,
      ST_ERR2
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   localparam logic [2:0] HSIZE_BYTE  = 3'b000;
   localparam logic [2:0] HSIZE_HALF  = 3'b001;
   localparam logic [2:0] HSIZE_WORD  = 3'b010;
   localparam logic [2:0] HSIZE_DWORD = 3'b011;

   // Sizes at or beyond the bus width select every lane.
   function automatic logic [7:0] strb_gen(
      input logic [2:0] size,
      input logic [2:0] addr,
      input int         nbytes
   );
      int         n;
      int         off;
      logic [7:0] m;
      n = 1 << size;
      if (n >= nbytes) begin
         m = 8'((1 << nbytes) - 1);
      end else begin
         off = int'(addr) & (nbytes - 1) & ~(n - 1);
         m   = 8'(((1 << n) - 1) << off);
      end
      return m;
   endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Maps an AHB address onto a one-hot APB slave select.
module apb_addr_decoder
   import bridge_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter int                NUM_SLAVES = 4,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
   parameter int                SLV_SHIFT  = 12
) (
   input  logic [ADDR_W-1:0]     haddr,
   output logic [NUM_SLAVES-1:0] hit,
   output logic                  miss
);

   logic [ADDR_W-1:0] off;
   logic [ADDR_W-1:0] win;
   logic              above;

   always_comb begin
      off   = haddr - BASE_ADDR;
      win   = off >> SLV_SHIFT;
      above = (haddr >= BASE_ADDR);
      hit   = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         hit[i] = above && (win == ADDR_W'(i));
      end
      miss = ~|hit;
   end

endmodule

// File: rtl/ahb_apb_bridge_mp.sv
// AHB-Lite to multi-slave APB bridge with wait states, error
// mapping, byte strobes and an access timeout.
module ahb_apb_bridge_mp
   import bridge_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter int                NUM_SLAVES = 4,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
   parameter int                SLV_SHIFT  = 12,
   parameter int                TIMEOUT    = 255
) (
   input  logic                         Hclk,
   input  logic                         Hresetn,
   input  logic [1:0]                   Htrans,
   input  logic                         Hwrite,
   input  logic                         Hreadyin,
   input  logic [2:0]                   Hsize,
   input  logic [ADDR_W-1:0]            Haddr,
   input  logic [DATA_W-1:0]            Hwdata,
   output logic                         Hreadyout,
   output logic [1:0]                   Hresp,
   output logic [DATA_W-1:0]            Hrdata,
   output logic [NUM_SLAVES-1:0]        Pselx,
   output logic                         Penable,
   output logic                         Pwrite,
   output logic [ADDR_W-1:0]            Paddr,
   output logic [DATA_W-1:0]            Pwdata,
   output logic [DATA_W/8-1:0]          Pstrb,
   input  logic [NUM_SLAVES*DATA_W-1:0] Prdata,
   input  logic [NUM_SLAVES-1:0]        Pready,
   input  logic [NUM_SLAVES-1:0]        Pslverr
);

   localparam int NB = DATA_W / 8;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] TMO_LAST =
      CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t                  state;
   logic [ADDR_W-1:0]       a_addr;
   logic [2:0]              a_size;
   logic [NUM_SLAVES-1:0]   a_hit;
   logic [CW-1:0]           cnt;

   logic [NUM_SLAVES-1:0]   hit;
   logic                    miss;
   logic                    accept;
   logic                    tmo_hit;
   logic                    pready_s;
   logic                    pslverr_s;
   logic [DATA_W-1:0]       rdata_s;
   logic [7:0]              strb_w;

   apb_addr_decoder #(
      .ADDR_W     (ADDR_W),
      .NUM_SLAVES (NUM_SLAVES),
      .BASE_ADDR  (BASE_ADDR),
      .SLV_SHIFT  (SLV_SHIFT)
   ) u_dec (
      .haddr (Haddr),
      .hit   (hit),
      .miss  (miss)
   );

   // Pselx stays stable through ACCESS, so it steers the return mux.
   always_comb begin
      rdata_s   = '0;
      pready_s  = 1'b0;
      pslverr_s = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (Pselx[i]) begin
            rdata_s   = rdata_s | Prdata[i*DATA_W +: DATA_W];
            pready_s  = pready_s | Pready[i];
            pslverr_s = pslverr_s | Pslverr[i];
         end
      end
      accept  = Hreadyin && Htrans[1] &&
                (state == ST_IDLE || state == ST_ERR2);
      tmo_hit = (TIMEOUT != 0) && (cnt == TMO_LAST);
      strb_w  = strb_gen(a_size, a_addr[2:0], NB);
   end

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state     <= ST_IDLE;
         a_addr    <= '0;
         a_size    <= '0;
         a_hit     <= '0;
         cnt       <= '0;
         Hreadyout <= 1'b1;
         Hresp     <= HRESP_OKAY;
         Hrdata    <= '0;
         Pselx     <= '0;
         Penable   <= 1'b0;
         Pwrite    <= 1'b0;
         Paddr     <= '0;
         Pwdata    <= '0;
         Pstrb     <= '0;
      end else begin
         unique case (state)
            ST_IDLE, ST_ERR2: begin
               state     <= ST_IDLE;
               Hreadyout <= 1'b1;
               Hresp     <= HRESP_OKAY;
               Pselx     <= '0;
               Penable   <= 1'b0;
               Pwrite    <= 1'b0;
               Paddr     <= '0;
               Pstrb     <= '0;
               if (accept) begin
                  a_addr    <= Haddr;
                  a_size    <= Hsize;
                  a_hit     <= hit;
                  Hreadyout <= 1'b0;
                  if (miss) begin
                     state <= ST_ERR1;
                     Hresp <= HRESP_ERROR;
                  end else if (Hwrite) begin
                     state <= ST_WWAIT;
                  end else begin
                     state <= ST_SETUP;
                     Pselx <= hit;
                     Paddr <= Haddr;
                  end
               end
            end
            ST_WWAIT: begin
               state  <= ST_SETUP;
               Pwdata <= Hwdata;
               Pselx  <= a_hit;
               Paddr  <= a_addr;
               Pwrite <= 1'b1;
               Pstrb  <= strb_w[NB-1:0];
            end
            ST_SETUP: begin
               state   <= ST_ACCESS;
               Penable <= 1'b1;
               cnt     <= '0;
            end
            ST_ACCESS: begin
               if (pready_s || tmo_hit) begin
                  Pselx   <= '0;
                  Penable <= 1'b0;
                  Pwrite  <= 1'b0;
                  Paddr   <= '0;
                  Pstrb   <= '0;
                  cnt     <= '0;
                  if (pready_s && !pslverr_s) begin
                     state     <= ST_IDLE;
                     Hreadyout <= 1'b1;
                     if (!Pwrite) begin
                        Hrdata <= rdata_s;
                     end
                  end else begin
                     state <= ST_ERR1;
                     Hresp <= HRESP_ERROR;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_ERR1: begin
               state     <= ST_ERR2;
               Hreadyout <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_apb_bridge_mp.sv
// Directed bench for the multi-slave AHB to APB bridge.
module tb_ahb_apb_bridge_mp;
   import bridge_pkg::*;

   logic         Hclk = 1'b0;
   logic         Hresetn;
   logic [1:0]   Htrans;
   logic         Hwrite;
   logic         Hreadyin;
   logic [2:0]   Hsize;
   logic [31:0]  Haddr;
   logic [31:0]  Hwdata;
   logic         Hreadyout;
   logic [1:0]   Hresp;
   logic [31:0]  Hrdata;
   logic [3:0]   Pselx;
   logic         Penable;
   logic         Pwrite;
   logic [31:0]  Paddr;
   logic [31:0]  Pwdata;
   logic [3:0]   Pstrb;
   logic [127:0] Prdata;
   logic [3:0]   Pready;
   logic [3:0]   Pslverr;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 Hclk = ~Hclk;

   ahb_apb_bridge_mp #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .NUM_SLAVES (4),
      .BASE_ADDR  (32'h8000_0000),
      .SLV_SHIFT  (12),
      .TIMEOUT    (8)
   ) dut (
      .Hclk      (Hclk),
      .Hresetn   (Hresetn),
      .Htrans    (Htrans),
      .Hwrite    (Hwrite),
      .Hreadyin  (Hreadyin),
      .Hsize     (Hsize),
      .Haddr     (Haddr),
      .Hwdata    (Hwdata),
      .Hreadyout (Hreadyout),
      .Hresp     (Hresp),
      .Hrdata    (Hrdata),
      .Pselx     (Pselx),
      .Penable   (Penable),
      .Pwrite    (Pwrite),
      .Paddr     (Paddr),
      .Pwdata    (Pwdata),
      .Pstrb     (Pstrb),
      .Prdata    (Prdata),
      .Pready    (Pready),
      .Pslverr   (Pslverr)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc;
      @(posedge Hclk);
      #1;
   endtask

   task automatic addr_ph(input logic [1:0] tr, input logic wr,
                          input logic [2:0] sz, input logic [31:0] a);
      Htrans = tr;
      Hwrite = wr;
      Hsize  = sz;
      Haddr  = a;
      cyc();
      Htrans = HTRANS_IDLE;
   endtask

   initial begin
      Hresetn  = 1'b0;
      Htrans   = HTRANS_IDLE;
      Hwrite   = 1'b0;
      Hreadyin = 1'b1;
      Hsize    = HSIZE_WORD;
      Haddr    = '0;
      Hwdata   = '0;
      Pready   = 4'hF;
      Pslverr  = 4'h0;
      Prdata   = {32'h1234_5678, 32'hC2C2_C2C2,
                  32'hB1B1_B1B1, 32'hA0A0_A0A0};
      #12;
      chk("rst_hready", 64'(Hreadyout), 64'd1);
      chk("rst_hresp",  64'(Hresp),     64'd0);
      chk("rst_psel",   64'(Pselx),     64'd0);
      chk("rst_hrdata", 64'(Hrdata),    64'd0);
      Hresetn = 1'b1;
      cyc();

      // word write to slave 1
      addr_ph(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h8000_1004);
      Hwdata = 32'hDEAD_BEEF;
      chk("wr_c1_hready", 64'(Hreadyout), 64'd0);
      cyc();
      chk("wr_c2_psel",  64'(Pselx),   64'h2);
      chk("wr_c2_paddr", 64'(Paddr),   64'h8000_1004);
      chk("wr_c2_pwdat", 64'(Pwdata),  64'hDEAD_BEEF);
      chk("wr_c2_pstrb", 64'(Pstrb),   64'hF);
      chk("wr_c2_pen",   64'(Penable), 64'd0);
      chk("wr_c2_pwr",   64'(Pwrite),  64'd1);
      cyc();
      chk("wr_c3_pen", 64'(Penable), 64'd1);
      cyc();
      chk("wr_c4_hready", 64'(Hreadyout), 64'd1);
      chk("wr_c4_hresp",  64'(Hresp),     64'd0);
      chk("wr_c4_psel",   64'(Pselx),     64'd0);
      chk("wr_c4_hrdata", 64'(Hrdata),    64'd0);

      // read slave 3 with two wait states
      Pready = 4'h7;
      addr_ph(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h8000_3010);
      chk("rd_c1_psel",  64'(Pselx), 64'h8);
      chk("rd_c1_pstrb", 64'(Pstrb), 64'h0);
      cyc();
      chk("rd_c2_pen", 64'(Penable), 64'd1);
      cyc();
      chk("rd_c3_pen", 64'(Penable), 64'd1);
      cyc();
      chk("rd_c4_pen", 64'(Penable), 64'd1);
      chk("rd_c4_hready", 64'(Hreadyout), 64'd0);
      Pready = 4'hF;
      cyc();
      chk("rd_c5_hready", 64'(Hreadyout), 64'd1);
      chk("rd_c5_hrdata", 64'(Hrdata),    64'h1234_5678);
      chk("rd_c5_pen",    64'(Penable),   64'd0);

      // decode miss then back-to-back read from ERR2
      addr_ph(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h8000_4000);
      chk("miss_c1_hresp",  64'(Hresp),     64'd1);
      chk("miss_c1_hready", 64'(Hreadyout), 64'd0);
      chk("miss_c1_psel",   64'(Pselx),     64'd0);
      cyc();
      chk("miss_c2_hresp",  64'(Hresp),     64'd1);
      chk("miss_c2_hready", 64'(Hreadyout), 64'd1);
      addr_ph(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h8000_0008);
      chk("b2b_psel",  64'(Pselx), 64'h1);
      chk("b2b_hresp", 64'(Hresp), 64'd0);
      cyc();
      cyc();
      chk("b2b_hready", 64'(Hreadyout), 64'd1);
      chk("b2b_hrdata", 64'(Hrdata),    64'hA0A0_A0A0);

      // slave error on a write
      Pslverr = 4'h2;
      addr_ph(HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h8000_1000);
      Hwdata = 32'h0BAD_0BAD;
      cyc();
      cyc();
      cyc();
      chk("serr_c4_hresp",  64'(Hresp),     64'd1);
      chk("serr_c4_hready", 64'(Hreadyout), 64'd0);
      chk("serr_c4_psel",   64'(Pselx),     64'd0);
      cyc();
      chk("serr_c5_hresp",  64'(Hresp),     64'd1);
      chk("serr_c5_hready", 64'(Hreadyout), 64'd1);
      Pslverr = 4'h0;
      cyc();
      chk("serr_c6_hresp", 64'(Hresp), 64'd0);

      // timeout after 8 ACCESS cycles
      Pready = 4'hB;
      addr_ph(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h8000_2000);
      cyc();
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("tmo_pen_%0d", k), 64'(Penable), 64'd1);
         cyc();
      end
      chk("tmo_pen_drop", 64'(Penable),   64'd0);
      chk("tmo_psel",     64'(Pselx),     64'd0);
      chk("tmo_hresp1",   64'(Hresp),     64'd1);
      chk("tmo_hready1",  64'(Hreadyout), 64'd0);
      cyc();
      chk("tmo_hresp2",  64'(Hresp),     64'd1);
      chk("tmo_hready2", 64'(Hreadyout), 64'd1);
      chk("tmo_hrdata",  64'(Hrdata),    64'hA0A0_A0A0);
      Pready = 4'hF;
      cyc();

      // byte, halfword and dword strobes
      addr_ph(HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h8000_0002);
      cyc();
      chk("strb_byte", 64'(Pstrb), 64'h4);
      cyc();
      cyc();
      addr_ph(HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h8000_0002);
      cyc();
      chk("strb_half", 64'(Pstrb), 64'hC);
      cyc();
      cyc();
      addr_ph(HTRANS_NONSEQ, 1'b1, HSIZE_DWORD, 32'h8000_0000);
      cyc();
      chk("strb_dword", 64'(Pstrb), 64'hF);
      cyc();
      cyc();
      chk("strb_idle", 64'(Pstrb), 64'h0);

      // BUSY and Hreadyin low are never accepted
      addr_ph(HTRANS_BUSY, 1'b0, HSIZE_WORD, 32'h8000_0000);
      chk("busy_psel",   64'(Pselx),     64'd0);
      chk("busy_hready", 64'(Hreadyout), 64'd1);
      Hreadyin = 1'b0;
      addr_ph(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h8000_0000);
      chk("nrdy_psel", 64'(Pselx), 64'd0);
      Hreadyin = 1'b1;

      // async reset during ACCESS, then a clean read
      Pready = 4'hE;
      addr_ph(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h8000_0000);
      cyc();
      chk("ar_pen_pre", 64'(Penable), 64'd1);
      #2;
      Hresetn = 1'b0;
      #1;
      chk("ar_pen",    64'(Penable),   64'd0);
      chk("ar_psel",   64'(Pselx),     64'd0);
      chk("ar_paddr",  64'(Paddr),     64'd0);
      chk("ar_hready", 64'(Hreadyout), 64'd1);
      chk("ar_hrdata", 64'(Hrdata),    64'd0);
      chk("ar_pwdata", 64'(Pwdata),    64'd0);
      #3;
      Hresetn = 1'b1;
      Pready  = 4'hF;
      cyc();
      addr_ph(HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h8000_2004);
      chk("ar_rd_psel", 64'(Pselx), 64'h4);
      cyc();
      cyc();
      chk("ar_rd_hready", 64'(Hreadyout), 64'd1);
      chk("ar_rd_hrdata", 64'(Hrdata),    64'hC2C2_C2C2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
